// File: rtl/mem_fd_initiator_if.sv
// Request/response bus between the self-test initiator and a single-port memory.
// A transfer completes on a posedge where valid_o && ready_i; the master holds
// addr_o/wdata_o/w_r_data_o stable until then, and rdata_i is meaningful only on read handshakes.
interface mem_fd_initiator_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [WIDTH-1:0]      wdata_o;
  logic                  w_r_data_o;
  logic                  valid_o;
  logic [WIDTH-1:0]      rdata_i;
  logic                  ready_i;

  modport master (
    output addr_o, wdata_o, w_r_data_o, valid_o,
    input  rdata_i, ready_i
  );

  modport slave (
    input  addr_o, wdata_o, w_r_data_o, valid_o,
    output rdata_i, ready_i
  );
endinterface

// File: rtl/mem_fd_initiator.sv
// Memory self-test engine: writes a seed-derived pattern to every word, reads it
// back, and reports pass/fail, mismatch count, first failing address and timeout.
module mem_fd_initiator #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      seed_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic                  timeout_o,
  output logic [1:0]            dbg_state_o,
  mem_fd_initiator_if.master    mem
);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, DONE = 2'd3} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [7:0]            WAIT_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      seed_q, seed_d;
  logic [ADDR_WIDTH:0]   err_q, err_d;
  logic [ADDR_WIDTH-1:0] fail_q, fail_d;
  logic                  tmo_q, tmo_d;
  logic                  pass_q, pass_d;
  logic [7:0]            wait_q, wait_d;
  logic [WIDTH-1:0]      exp_word;
  logic                  handshake;

  // Odd addresses get the inverted word so adjacent cells see opposite bit values.
  function automatic logic [WIDTH-1:0] pattern(input logic [WIDTH-1:0] s,
                                               input logic [ADDR_WIDTH-1:0] a);
    return s ^ WIDTH'(a) ^ {WIDTH{a[0]}};
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      tmo_q   <= 1'b0;
      pass_q  <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
      pass_q  <= pass_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    seed_d    = seed_q;
    err_d     = err_q;
    fail_d    = fail_q;
    tmo_d     = tmo_q;
    pass_d    = pass_q;
    wait_d    = wait_q;
    exp_word  = pattern(seed_q, addr_q);
    handshake = mem.valid_o && mem.ready_i;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = WRITE;
          seed_d  = seed_i;
          addr_d  = '0;
          err_d   = '0;
          fail_d  = '0;
          tmo_d   = 1'b0;
          pass_d  = 1'b0;
          wait_d  = '0;
        end
      end
      WRITE, READ: begin
        if (handshake) begin
          wait_d = '0;
          if (state_q == READ && mem.rdata_i != exp_word) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (err_q == '0) fail_d = addr_q;
          end
          if (addr_q == LAST_ADDR) begin
            if (state_q == WRITE) begin
              state_d = READ;
              addr_d  = '0;
            end else begin
              state_d = DONE;
              pass_d  = (err_d == '0) && !tmo_q;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          // Responder stalled too long: abandon the test at the stuck address.
          state_d = DONE;
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
          wait_d  = '0;
          if (err_q == '0) fail_d = addr_q;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.valid_o    = (state_q == WRITE) || (state_q == READ);
  assign mem.w_r_data_o = (state_q == WRITE);
  assign mem.addr_o     = addr_q;
  assign mem.wdata_o    = (state_q == WRITE) ? exp_word : '0;

  assign busy_o      = mem.valid_o;
  assign done_o      = (state_q == DONE);
  assign pass_o      = pass_q;
  assign err_cnt_o   = err_q;
  assign fail_addr_o = fail_q;
  assign timeout_o   = tmo_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/mem_fd_initiator.md
Name: mem_fd_initiator

Overview:
- Synthesizable front-door initiator (master) for the team's valid/ready single-port memory.
- Drives addr/wdata/write-read/valid toward the memory and consumes ready and read data.
- On start it runs a full write pass of a seed-derived pattern over every address, then a read-back pass comparing each word.
- Reports pass/fail, error count, first failing address and handshake timeout; used as an on-chip memory self-test engine.

Parameters:
- WIDTH, 16: data word width.
- DEPTH, 64: number of words tested; DEPTH <= 2**ADDR_WIDTH.
- ADDR_WIDTH, 6: address width.
- TIMEOUT, 16: max consecutive cycles valid_o may wait for ready_i; range 1..255.

Ports:
- clk_i  in  1  single clock, all logic on posedge.
- rst_i  in  1  synchronous, active-low reset.
- start_i  in  1  begin test; sampled only when not busy.
- seed_i  in  WIDTH  pattern seed, latched on accepted start.
- busy_o  out  1  high from the cycle after an accepted start until done.
- done_o  out  1  level; high after test end until the next accepted start.
- pass_o  out  1  valid when done_o=1; 1 = no mismatches and no timeout.
- err_cnt_o  out  ADDR_WIDTH+1  read mismatch count, saturating at all-ones.
- fail_addr_o  out  ADDR_WIDTH  address of the first mismatch (or of the timeout); 0 if none.
- timeout_o  out  1  test aborted on handshake timeout.
- addr_o  out  ADDR_WIDTH  memory address.
- wdata_o  out  WIDTH  write data; 0 during the read pass.
- w_r_data_o  out  1  1 = write, 0 = read.
- valid_o  out  1  request valid.
- rdata_i  in  WIDTH  read data; sampled only on a read handshake.
- ready_i  in  1  responder accepts the request / read data valid.

Behaviour:

Reset:
- rst_i low at a posedge sets every output and internal register to 0, state to IDLE.
- Reset mid-operation aborts immediately. valid_o is 0 the cycle after the reset edge. No partial result is retained.

Pattern:
- exp(a) = seed ^ zero-extended a ^ {WIDTH{a[0]}} (alternating inversion).
- Same function for the write data and the read expectation.

Handshake:
- A transfer completes at a posedge where valid_o && ready_i.
- addr_o, wdata_o and w_r_data_o are held stable while valid_o=1 and not yet accepted.
- valid_o never drops without a handshake, except on timeout or reset.
- Back-to-back transfers: the next request is presented in the cycle after a handshake, with valid_o staying high.

States:
- IDLE/DONE: valid_o=0. start_i=1 latches the seed and clears done_o, pass_o, err_cnt_o, fail_addr_o and timeout_o. Next cycle: WRITE, addr_o=0, w_r_data_o=1, valid_o=1, busy_o=1.
- WRITE: on handshake, if addr=DEPTH-1 go to READ with addr_o=0 and w_r_data_o=0; else addr_o+1.
- READ: on handshake, compare rdata_i to exp(addr_o).
  - On mismatch, err_cnt_o increments (saturating).
  - If this is the first mismatch, fail_addr_o = addr_o.
  - If addr=DEPTH-1, go to DONE; else addr_o+1.
- DONE: valid_o=0, busy_o=0, done_o=1.
  - pass_o = (err_cnt==0, including the final compare) && !timeout_o.
  - start_i restarts the test.

Timeout:
- The wait counter increments each cycle valid_o && !ready_i and clears on every handshake.
- When the counter reaches TIMEOUT, the next state is DONE with timeout_o=1 and pass_o=0.
- fail_addr_o is set to the stalled address only if no earlier mismatch was recorded.

Start handling:
- start_i while busy_o=1 is ignored.
- start_i and reset in the same cycle: reset wins.

Latency:
- With ready_i tied high, the handshakes occur in cycles 1..2*DEPTH after the start edge (cycle 0).
- done_o rises at cycle 2*DEPTH+1 (129 for defaults).

Test Plan:
- Ideal responder: ready_i=1, correct memory, seed 16'hA5A5 → 64 writes then 64 reads; done_o at cycle 129; pass_o=1; err_cnt_o=0. Words written: addr0=16'hA5A5, addr1=16'h5A5B.
- Fault injection: responder flips bit0 of the read data at addrs 5 and 40 → err_cnt_o=2, fail_addr_o=5, pass_o=0.
- Backpressure: ready_i delayed randomly 0..3 cycles per request → addr/wdata/w_r stable while stalled, pass_o=1, exactly 128 handshakes.
- Timeout: ready_i stuck low from write addr 10 → 16 stall cycles, then done_o=1, timeout_o=1, fail_addr_o=10, valid_o=0, pass_o=0.
- Reset mid read pass at addr 30 → next cycle all outputs 0; a fresh start then completes with pass_o=1.
- start_i pulsed at cycle 50 of a running test → ignored; the result is identical to the undisturbed run.
